// File: rtl/aes_dec_pkg.sv
// Shared types, tables and GF(2^8) helpers for the iterative AES inverse cipher.
// Byte 0 of a word or block always sits in the most significant bits.
package aes_dec_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {StIdle, StExpand, StRound, StHold} dec_state_e;

  // Word store depth covers the largest (256-bit) schedule.
  localparam int unsigned MaxWords = 60;

  function automatic int unsigned nk_of(int unsigned key_size);
    return key_size / 32;
  endfunction

  function automatic int unsigned nr_of(int unsigned key_size);
    return key_size / 32 + 6;
  endfunction

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Entry 0 is unused so the table is indexed directly by i/Nk.
  localparam logic [7:0] Rcon [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(word_t w);
    word_t o;
    for (int b = 0; b < 4; b++) begin
      o[31-8*b -: 8] = Sbox[w[31-8*b -: 8]];
    end
    return o;
  endfunction

  function automatic block_t inv_shift_rows(block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(block_t s);
    block_t o;
    for (int b = 0; b < 16; b++) begin
      o[127-8*b -: 8] = InvSbox[s[127-8*b -: 8]];
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of b, 2b, 4b and 8b.
  function automatic logic [7:0] gf_mul_c(logic [7:0] b, logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic block_t inv_mix_columns(block_t s);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^
                              gf_mul_c(a3, 4'h9);
      o[127-8*(4*c+1) -: 8] = gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^
                              gf_mul_c(a3, 4'hd);
      o[127-8*(4*c+2) -: 8] = gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^
                              gf_mul_c(a3, 4'hb);
      o[127-8*(4*c+3) -: 8] = gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^
                              gf_mul_c(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One combinational inverse-cipher step: initial AddRoundKey, a full inverse round,
// or the final round without InvMixColumns.
module inv_round_comb
  import aes_dec_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  input  logic   is_first_i,
  input  logic   is_last_i,
  output block_t state_o
);

  block_t sub_shift;

  always_comb begin
    sub_shift = inv_sub_bytes(inv_shift_rows(state_i));
    if (is_first_i) begin
      state_o = state_i ^ rk_i;
    end else if (is_last_i) begin
      state_o = sub_shift ^ rk_i;
    end else begin
      state_o = inv_mix_columns(sub_shift ^ rk_i);
    end
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: expands the key schedule one word per cycle, then
// runs one inverse round per cycle from the last round key down to rk[0].
module aes_decrypt_iter
  import aes_dec_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        ciphertext,
  input  logic [KEY_SIZE-1:0] initialKey,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        plaintext
);

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : gen_bad_key_size
    $error("aes_decrypt_iter: KEY_SIZE must be 128, 192 or 256");
  end

  localparam int unsigned Nk       = nk_of(KEY_SIZE);
  localparam int unsigned Nr       = nr_of(KEY_SIZE);
  localparam int unsigned NumWords = 4 * (Nr + 1);

  dec_state_e  state_q, state_d;
  word_t       w_q [MaxWords];
  word_t       w_d [MaxWords];
  logic [5:0]  widx_q, widx_d;
  logic [2:0]  phase_q, phase_d;      // widx_q % Nk, kept as a counter
  logic [3:0]  rcon_idx_q, rcon_idx_d; // widx_q / Nk, kept as a counter
  logic [3:0]  rnd_q, rnd_d;
  block_t      blk_q, blk_d;
  block_t      pt_q, pt_d;

  word_t       prev_w, temp_w, new_w;
  logic [5:0]  rk_base;
  block_t      rk;
  block_t      round_out;
  logic        is_first, is_last;

  always_comb begin
    prev_w = w_q[widx_q - 6'd1];
    if (phase_q == 3'd0) begin
      temp_w = sub_word(rot_word(prev_w)) ^ {Rcon[rcon_idx_q], 24'h000000};
    end else if (Nk == 8 && phase_q == 3'd4) begin
      temp_w = sub_word(prev_w);
    end else begin
      temp_w = prev_w;
    end
    new_w = w_q[widx_q - 6'(Nk)] ^ temp_w;
  end

  assign rk_base  = {rnd_q, 2'b00};
  assign rk       = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
  assign is_first = (rnd_q == 4'(Nr));
  assign is_last  = (rnd_q == 4'd0);

  inv_round_comb u_inv_round (
    .state_i    (blk_q),
    .rk_i       (rk),
    .is_first_i (is_first),
    .is_last_i  (is_last),
    .state_o    (round_out)
  );

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    widx_d     = widx_q;
    phase_d    = phase_q;
    rcon_idx_d = rcon_idx_q;
    rnd_d      = rnd_q;
    blk_d      = blk_q;
    pt_d       = pt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          blk_d = ciphertext;
          for (int k = 0; k < Nk; k++) begin
            w_d[k] = initialKey[KEY_SIZE-1-32*k -: 32];
          end
          widx_d     = 6'(Nk);
          phase_d    = 3'd0;
          rcon_idx_d = 4'd1;
          state_d    = StExpand;
        end
      end
      StExpand: begin
        w_d[widx_q] = new_w;
        widx_d      = widx_q + 6'd1;
        if (phase_q == 3'(Nk - 1)) begin
          phase_d    = 3'd0;
          rcon_idx_d = rcon_idx_q + 4'd1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
        if (widx_q == 6'(NumWords - 1)) begin
          rnd_d   = 4'(Nr);
          state_d = StRound;
        end
      end
      StRound: begin
        blk_d = round_out;
        if (is_last) begin
          pt_d    = round_out;
          state_d = StHold;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      for (int k = 0; k < MaxWords; k++) begin
        w_q[k] <= '0;
      end
      widx_q     <= '0;
      phase_q    <= '0;
      rcon_idx_q <= '0;
      rnd_q      <= '0;
      blk_q      <= '0;
      pt_q       <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      widx_q     <= widx_d;
      phase_q    <= phase_d;
      rcon_idx_q <= rcon_idx_d;
      rnd_q      <= rnd_d;
      blk_q      <= blk_d;
      pt_q       <= pt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: three instances (128/192/256) checked every cycle against a
// handshake/latency model, with ciphertexts produced by a byte-level forward AES model.
module tb_aes_decrypt_iter;

  localparam int Lat [3] = '{51, 59, 67};
  localparam int Nks [3] = '{4, 6, 8};

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FipsPt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   in_valid = '0;
  logic [2:0]   out_ready = '1;
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  logic [127:0] ct [3];
  logic [255:0] key [3];
  wire  [127:0] pt_o [3];

  int           errors = 0;
  int           checks = 0;
  int           edges = 0;
  logic [7:0]   sbox_m [256];

  // Model state per instance
  bit           busy [3];
  int           acc_e [3];
  logic [127:0] hold_pt [3];
  logic [127:0] drv_pt [3];
  int           n_out_m [3];
  int           n_out_d [3];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  aes_decrypt_iter #(.KEY_SIZE(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ciphertext(ct[0]),
    .initialKey(key[0][255:128]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .plaintext(pt_o[0])
  );
  aes_decrypt_iter #(.KEY_SIZE(192)) u_dut192 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ciphertext(ct[1]),
    .initialKey(key[1][255:64]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .plaintext(pt_o[1])
  );
  aes_decrypt_iter #(.KEY_SIZE(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .ciphertext(ct[2]),
    .initialKey(key[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .plaintext(pt_o[2])
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward AES over byte arrays; s[4c+r] is row r of column c.
  function automatic logic [127:0] aes_enc(logic [255:0] kk, int nk, logic [127:0] p);
    logic [7:0]   w [60][4];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   x, rc;
    logic [127:0] o;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][j] = kk[255-8*(4*i+j) -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % nk == 0) begin
        x = tmp[0];
        tmp[0] = tmp[1]; tmp[1] = tmp[2]; tmp[2] = tmp[3]; tmp[3] = x;
        for (int j = 0; j < 4; j++) tmp[j] = sbox_m[tmp[j]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_m[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ tmp[j];
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][b%4];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_m[s[b]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) tmp[q] = s[4*c+q];
          for (int q = 0; q < 4; q++)
            s[4*c+q] = gmul(tmp[q], 8'h02) ^ gmul(tmp[(q+1)%4], 8'h03) ^ tmp[(q+2)%4] ^
                       tmp[(q+3)%4];
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][b%4];
    end
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  // Per-cycle compare against the handshake/latency model.
  initial begin
    bit exp_ov;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst) begin
          chk($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1);
          chk($sformatf("rst_out_valid[%0d]", k), out_valid[k], 0);
          chk($sformatf("rst_plaintext[%0d]", k), pt_o[k], 0);
          busy[k] = 1'b0;
        end else begin
          exp_ov = busy[k] && (edges >= acc_e[k] + Lat[k]);
          chk($sformatf("in_ready[%0d]@%0d", k, edges), in_ready[k], !busy[k]);
          chk($sformatf("out_valid[%0d]@%0d", k, edges), out_valid[k], exp_ov);
          if (exp_ov) chk($sformatf("plaintext[%0d]@%0d", k, edges), pt_o[k], hold_pt[k]);
          if (out_valid[k] && out_ready[k]) n_out_d[k]++;
          if (exp_ov && out_ready[k]) begin
            busy[k] = 1'b0;
            n_out_m[k]++;
          end else if (!busy[k] && in_valid[k]) begin
            busy[k]    = 1'b1;
            acc_e[k]   = edges + 1;
            hold_pt[k] = drv_pt[k];
          end
        end
      end
    end
  end

  task automatic send_ct(input int k, input logic [255:0] kk, input logic [127:0] c,
                         input logic [127:0] p);
    bit ok = 1'b0;
    key[k]      = kk;
    ct[k]       = c;
    drv_pt[k]   = p;
    in_valid[k] = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready[k];
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    ct[k]       = ~c;
    key[k]      = ~kk;
    if (!ok) fail_timeout($sformatf("accept[%0d]", k));
  endtask

  task automatic wait_done(input int k);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk);
      #1;
      done = !busy[k];
    end
    if (!done) fail_timeout($sformatf("done[%0d]", k));
  endtask

  task automatic rand_run(input int k, input int n);
    logic [255:0] kk;
    logic [127:0] p;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) kk = {kk[223:0], 32'($urandom)};
      for (int j = 0; j < 4; j++) p = {p[95:0], 32'($urandom)};
      if (k == 0) kk[127:0] = '0;
      if (k == 1) kk[63:0] = '0;
      send_ct(k, kk, aes_enc(kk, Nks[k], p), p);
    end
    wait_done(k);
  endtask

  initial begin
    logic [7:0]   inv, sv;
    logic [255:0] kb;
    logic [127:0] pb;
    bit           seen;
    for (int i = 0; i < 3; i++) begin
      ct[i] = '0; key[i] = '0; drv_pt[i] = '0; hold_pt[i] = '0;
      busy[i] = 1'b0; acc_e[i] = 0; n_out_m[i] = 0; n_out_d[i] = 0;
    end
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sv = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x] = sv;
    end
    chk("model_fips128", aes_enc(K128, 4, FipsPt), Ct128);
    chk("model_fips192", aes_enc(K192, 6, FipsPt), Ct192);
    chk("model_fips256", aes_enc(K256, 8, FipsPt), Ct256);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // FIPS-197 vectors, one per key size
    fork
      begin send_ct(0, K128, Ct128, FipsPt); wait_done(0); end
      begin send_ct(1, K192, Ct192, FipsPt); wait_done(1); end
      begin send_ct(2, K256, Ct256, FipsPt); wait_done(2); end
    join

    // Backpressure: hold out_ready low for 20 cycles while a new block waits
    kb = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0badf00d, 128'h0};
    pb = 128'hfedcba98765432100123456789abcdef;
    out_ready[0] = 1'b0;
    fork
      begin
        send_ct(0, K128, Ct128, FipsPt);
        send_ct(0, kb, aes_enc(kb, 4, pb), pb);
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
          @(posedge clk);
          #1;
          seen = out_valid[0];
        end
        if (!seen) fail_timeout("backpressure_out_valid");
        repeat (20) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    wait_done(0);

    // Reset 30 cycles into a decrypt, then a clean FIPS decrypt
    send_ct(0, K128, Ct128, FipsPt);
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_plaintext", pt_o[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send_ct(0, K128, Ct128, FipsPt);
    wait_done(0);

    fork
      rand_run(0, 200);
      rand_run(1, 20);
      rand_run(2, 20);
    join

    for (int k = 0; k < 3; k++)
      chk($sformatf("handshakes_vs_model[%0d]", k), n_out_d[k], n_out_m[k]);
    chk("handshakes[0]", n_out_d[0], 204);
    chk("handshakes[1]", n_out_d[1], 21);
    chk("handshakes[2]", n_out_d[2], 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
